btn_select_debounce: RTL and testbench
======================================

// Module: btn_select_debounce
// PURPOSE
//  Front end for the RGB LED colour/PWM stage. Takes 8 raw, bouncy, asynchronous push buttons,
//  synchronises and debounces each one, and turns debounced press edges into a one-cycle one-hot
//  select pulse. The pulse drives the 8-bit one-hot btn input of the colour/PWM stage directly.
//  Also keeps the last accepted selection (index plus valid) and a press counter for status/7-seg.
// PARAMETERS
//  N_BTN     8        number of buttons; btn_raw/btn_sel width
//  DB_LIMIT  1000000  cycles a raw level must stay stable before acceptance (10 ms @ 100 MHz); >=2
//  DB_W      20       debounce counter width; must satisfy 2**DB_W > DB_LIMIT
// PORTS
//  clk        in   1      system clock; all logic on posedge clk
//  rst        in   1      asynchronous, active-high reset
//  btn_raw    in   N_BTN  raw button levels, 1 = pressed, asynchronous to clk
//  btn_sel    out  N_BTN  one-hot press pulse, high exactly 1 cycle per accepted press, else 0
//  sel_idx    out  3      index of last accepted press (log2 N_BTN bits)
//  sel_valid  out  1      set on first accepted press after reset; sticky until reset
//  press_cnt  out  8      count of accepted presses, wraps 255 -> 0
// BEHAVIOUR
//  - Reset (async assert, sync release): sync flops, stable levels, debounce counters, btn_sel,
//    sel_idx, sel_valid and press_cnt are all 0.
//  - Per bit: 2-FF synchroniser, btn_raw -> s1 -> s2.
//  - Per bit debounce, each posedge:
//      s2 == stable                  -> cnt <= 0
//      s2 != stable, cnt < DB_LIMIT-1 -> cnt <= cnt+1
//      s2 != stable, cnt == DB_LIMIT-1 -> stable <= s2, cnt <= 0
//    A bounce back to the stable level before the limit clears cnt, so the acceptance window restarts.
//  - Edge detect: stable_q <= stable each cycle; rise = stable & ~stable_q. Release edges are ignored.
//  - Arbitration: if rise != 0, the lowest set index k wins.
//      btn_sel <= (1 << k), sel_idx <= k, sel_valid <= 1, press_cnt <= press_cnt + 1 (mod 256).
//    Simultaneous rises on other bits are dropped, not queued.
//    If rise == 0: btn_sel <= 0; sel_idx, sel_valid and press_cnt hold.
//  - Latency: with a clean raw rise captured at edge 1, btn_sel is high after edge DB_LIMIT+3,
//    for exactly one cycle.
//  - A press while another button is held is accepted normally; holding a button gives one pulse only.
//  - Buttons already held when rst deasserts: stable starts at 0, so each is accepted as a press
//    DB_LIMIT+3 cycles after release of reset.
//  - rst mid-debounce or mid-pulse: everything returns to 0 immediately. No pulse is emitted
//    because of the reset itself.
//  - btn_sel is always 0 or exactly one-hot, never multi-hot.
// STRUCTURE
//  - Shared package/include led_ctrl_pkg: N_BTN, DB_LIMIT, DB_LIMIT_SIM (=4 for benches) and
//    colour index constants 0..7 (red .. white), matching the select order of the PWM stage.
//  - Sub-module btn_debounce_bit (params DB_LIMIT, DB_W; ports clk, rst, raw, stable).
//    Instantiated N_BTN times with generate; this block adds edge detect, priority encode and
//    the status registers.
// TESTING (DB_LIMIT=4)
//  1. Reset: rst=1 with random btn_raw -> all outputs 0. Release with btn_raw=0 for 20 cycles
//     -> btn_sel stays 0, sel_valid=0.
//  2. Clean press: btn_raw=8'h04 held -> btn_sel=8'h04 for 1 cycle, 7 cycles after the capture
//     edge. Then sel_idx=2, sel_valid=1, press_cnt=1, and btn_sel=0 while the button stays held.
//  3. Bounce: btn_raw[5] toggled every 2 cycles for 20 cycles, then held 1 -> exactly one
//     btn_sel=8'h20 pulse, 7 cycles after the last toggle capture. No pulse on the later release.
//  4. Simultaneous: btn_raw 0 -> 8'h81 in the same cycle -> single pulse 8'h01, sel_idx=0.
//     Bit 7 is dropped; press_cnt increments by 1 only.
//  5. Wrap and held-through-reset: 256 clean presses of bit 3 -> press_cnt returns to 0,
//     sel_idx=3. Then rst pulse with bit 6 held -> outputs 0, then 8'h40 pulse 7 cycles after release.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED colour/PWM path: button count, debounce limits, colour indices.
// Colour indices follow the select order of the PWM stage (btn_sel bit k selects colour k).
package led_ctrl_pkg;

  localparam int N_BTN        = 8;
  localparam int DB_LIMIT     = 1000000;
  localparam int DB_LIMIT_SIM = 4;
  localparam int DB_W         = 20;

  typedef enum logic [2:0] {
    COL_RED     = 3'd0,
    COL_GREEN   = 3'd1,
    COL_BLUE    = 3'd2,
    COL_YELLOW  = 3'd3,
    COL_CYAN    = 3'd4,
    COL_MAGENTA = 3'd5,
    COL_PURPLE  = 3'd6,
    COL_WHITE   = 3'd7
  } colour_e;

endpackage

// File: rtl/btn_debounce_bit.sv
// One button: 2-FF synchroniser then a level must hold DB_LIMIT cycles before it becomes stable.
// Latency: raw change reaches stable DB_LIMIT+2 edges after capture; no backpressure.
module btn_debounce_bit
  import led_ctrl_pkg::*;
#(
  parameter int DB_LIMIT = led_ctrl_pkg::DB_LIMIT,
  parameter int DB_W     = led_ctrl_pkg::DB_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  logic            s1;
  logic            s2;
  logic [DB_W-1:0] cnt;

  // Any return to the stable level clears cnt, so the window restarts on every bounce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_LIMIT - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/btn_select_debounce.sv
// Debounces N_BTN buttons and turns press edges into a one-cycle one-hot select plus status.
// Latency: pulse DB_LIMIT+3 edges after raw capture; lowest index wins, other rises are dropped.
module btn_select_debounce #(
  parameter int N_BTN    = led_ctrl_pkg::N_BTN,
  parameter int DB_LIMIT = led_ctrl_pkg::DB_LIMIT,
  parameter int DB_W     = led_ctrl_pkg::DB_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_raw,
  output logic [N_BTN-1:0]         btn_sel,
  output logic [$clog2(N_BTN)-1:0] sel_idx,
  output logic                     sel_valid,
  output logic [7:0]               press_cnt
);
  import led_ctrl_pkg::*;

  localparam int IDX_W = $clog2(N_BTN);

  logic [N_BTN-1:0] stable;
  logic [N_BTN-1:0] stable_q;
  logic [N_BTN-1:0] rise;
  logic [IDX_W-1:0] win;

  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    btn_debounce_bit #(
      .DB_LIMIT(DB_LIMIT),
      .DB_W    (DB_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[g]),
      .stable(stable[g])
    );
  end

  // Release edges are ignored; only 0->1 of the debounced level counts as a press.
  assign rise = stable & ~stable_q;

  always_comb begin
    win = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) win = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q  <= '0;
      btn_sel   <= '0;
      sel_idx   <= '0;
      sel_valid <= 1'b0;
      press_cnt <= '0;
    end else begin
      stable_q <= stable;
      if (|rise) begin
        btn_sel   <= N_BTN'(1) << win;
        sel_idx   <= win;
        sel_valid <= 1'b1;
        press_cnt <= press_cnt + 8'd1;
      end else begin
        btn_sel <= '0;
      end
    end
  end

endmodule

// File: tb/tb_btn_select_debounce.sv
// Bench for btn_select_debounce with a short debounce window; window-rule model plus directed checks.
module tb_btn_select_debounce;

  localparam int DBL = led_ctrl_pkg::DB_LIMIT_SIM;

  logic       clk;
  logic       rst;
  logic [7:0] btn_raw;
  logic [7:0] btn_sel;
  logic [2:0] sel_idx;
  logic       sel_valid;
  logic [7:0] press_cnt;

  int total = 0;
  int bad   = 0;
  bit done  = 0;

  btn_select_debounce #(
    .N_BTN   (8),
    .DB_LIMIT(DBL),
    .DB_W    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_sel  (btn_sel),
    .sel_idx  (sel_idx),
    .sel_valid(sel_valid),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a button's accepted level flips once the raw samples seen by the
  // debouncer (taken two edges earlier) have disagreed with it for DBL edges in a row.
  logic [7:0] hist [0:DBL+1];
  logic [7:0] m_stable, m_pend, m_sel, m_cnt, nxt;
  logic [2:0] m_idx;
  logic       m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= DBL + 1; j++) hist[j] = 8'h00;
      m_stable = 8'h00; m_pend = 8'h00; m_sel = 8'h00;
      m_cnt = 8'h00; m_idx = 3'd0; m_valid = 1'b0;
    end else begin
      if (m_pend != 8'h00) begin
        int k;
        bit found;
        k = 0; found = 0;
        for (int b = 0; b < 8; b++) if (!found && m_pend[b]) begin k = b; found = 1; end
        m_sel   = 8'h01 << k;
        m_idx   = k[2:0];
        m_valid = 1'b1;
        m_cnt   = m_cnt + 8'd1;
      end else begin
        m_sel = 8'h00;
      end
      for (int j = DBL + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = btn_raw;
      nxt = m_stable;
      for (int b = 0; b < 8; b++) begin
        bit agree;
        agree = 1;
        for (int j = 2; j <= DBL + 1; j++) if (hist[j][b] == m_stable[b]) agree = 0;
        if (agree) nxt[b] = ~m_stable[b];
      end
      m_pend   = nxt & ~m_stable;
      m_stable = nxt;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!done) begin
        chk("sel",    btn_sel, m_sel);
        chk("idx",    {5'b0, sel_idx}, {5'b0, m_idx});
        chk("valid",  {7'b0, sel_valid}, {7'b0, m_valid});
        chk("cnt",    press_cnt, m_cnt);
        chk("onehot", {7'b0, $onehot0(btn_sel)}, 8'h01);
      end
    end
  end

  initial begin
    rst     = 1'b1;
    btn_raw = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_sel",   btn_sel, 8'h00);
    chk("rst_idx",   {5'b0, sel_idx}, 8'h00);
    chk("rst_valid", {7'b0, sel_valid}, 8'h00);
    chk("rst_cnt",   press_cnt, 8'h00);
    btn_raw = 8'h00;
    rst     = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_valid", {7'b0, sel_valid}, 8'h00);
    chk("idle_sel",   btn_sel, 8'h00);

    // Clean press of bit 2: pulse after the 7th edge from capture.
    btn_raw = 8'h04;
    repeat (6) @(negedge clk);
    chk("p2_early", btn_sel, 8'h00);
    @(negedge clk);
    chk("p2_pulse", btn_sel, 8'h04);
    @(negedge clk);
    chk("p2_end",   btn_sel, 8'h00);
    chk("p2_idx",   {5'b0, sel_idx}, 8'd2);
    chk("p2_valid", {7'b0, sel_valid}, 8'h01);
    chk("p2_cnt",   press_cnt, 8'd1);
    repeat (10) @(negedge clk);
    chk("p2_held", press_cnt, 8'd1);
    btn_raw = 8'h00;
    repeat (12) @(negedge clk);

    // Bounce on bit 5, then a clean hold.
    for (int i = 0; i < 10; i++) begin
      btn_raw = (i % 2 == 0) ? 8'h20 : 8'h00;
      repeat (2) @(negedge clk);
    end
    chk("b5_none", press_cnt, 8'd1);
    btn_raw = 8'h20;
    repeat (6) @(negedge clk);
    chk("b5_early", btn_sel, 8'h00);
    @(negedge clk);
    chk("b5_pulse", btn_sel, 8'h20);
    @(negedge clk);
    chk("b5_idx", {5'b0, sel_idx}, 8'd5);
    chk("b5_cnt", press_cnt, 8'd2);
    repeat (10) @(negedge clk);
    btn_raw = 8'h00;
    repeat (12) @(negedge clk);
    chk("b5_release", press_cnt, 8'd2);

    // Simultaneous rise of bits 0 and 7.
    btn_raw = 8'h81;
    repeat (7) @(negedge clk);
    chk("sim_pulse", btn_sel, 8'h01);
    @(negedge clk);
    chk("sim_idx", {5'b0, sel_idx}, 8'd0);
    chk("sim_cnt", press_cnt, 8'd3);
    repeat (12) @(negedge clk);
    chk("sim_drop", press_cnt, 8'd3);
    btn_raw = 8'h00;
    repeat (12) @(negedge clk);

    // Counter wrap from a fresh reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 256; n++) begin
      btn_raw = 8'h08;
      repeat (10) @(negedge clk);
      btn_raw = 8'h00;
      repeat (10) @(negedge clk);
      if (n == 254) chk("wrap_255", press_cnt, 8'd255);
    end
    chk("wrap_0",     press_cnt, 8'd0);
    chk("wrap_idx",   {5'b0, sel_idx}, 8'd3);
    chk("wrap_valid", {7'b0, sel_valid}, 8'h01);

    // Reset with bit 6 held: press accepted after release.
    btn_raw = 8'h40;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("hr_sel",   btn_sel, 8'h00);
    chk("hr_valid", {7'b0, sel_valid}, 8'h00);
    chk("hr_cnt",   press_cnt, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("hr_early", btn_sel, 8'h00);
    @(negedge clk);
    chk("hr_pulse", btn_sel, 8'h40);
    @(negedge clk);
    chk("hr_idx", {5'b0, sel_idx}, 8'd6);
    chk("hr_cnt1", press_cnt, 8'd1);
    repeat (5) @(negedge clk);

    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
